// File: rtl/vga_timing_gen.sv
// VGA timing generator with a registered colour stage.
//
// The pixel rate is half of Clk: pix_en toggles on every Clk edge, and each edge where pix_en is
// high is a pixel edge. On a pixel edge the DrawX/DrawY counters advance. On the same edge the
// sync, blank and colour outputs are registered from the current counter position. The
// registered outputs therefore lag the counters by exactly one pixel period (2 Clk).
//
// Ports:
//   Clk            system clock
//   Reset          synchronous active-low reset
//   Red/Green/Blue colour for the current DrawX/DrawY, sampled only on pixel edges
//   pixel_clk      pixel enable (pix_en), high every second Clk
//   DrawX/DrawY    current pixel / line counters
//   hs/vs          active-low syncs, aligned with VGA_R/G/B
//   blank_n        high while the output pixel is visible
//   frame_start    one-Clk pulse after the counters wrap to (0,0)
//   VGA_R/G/B      registered colour to the DAC, forced to zero outside the visible area
module vga_timing_gen #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic       pixel_clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX     = 10'(H_TOT - 1);
    localparam logic [9:0] V_MAX     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0] HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);

    logic       pix_en_q;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, vs_q, blank_n_q, frame_start_q;
    logic [7:0] r_q, g_q, b_q;

    logic       x_end, y_end;
    logic       vis0, hs0, vs0;

    // Counter next-state and stage-0 decode of the current position.
    always_comb begin
        x_end = (x_q == H_MAX);
        y_end = (y_q == V_MAX);
        x_d   = x_q;
        y_d   = y_q;
        if (pix_en_q) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        vis0 = (x_q < H_VIS_W) && (y_q < V_VIS_W);
        hs0  = !((x_q >= HS_START) && (x_q < HS_END));
        vs0  = !((y_q >= VS_START) && (y_q < VS_END));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pix_en_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            pix_en_q      <= ~pix_en_q;
            x_q           <= x_d;
            y_q           <= y_d;
            // Set only by the wrapping pixel edge; the following edge never has pix_en high,
            // so the pulse is exactly one Clk wide.
            frame_start_q <= pix_en_q && x_end && y_end;
            if (pix_en_q) begin
                hs_q      <= hs0;
                vs_q      <= vs0;
                blank_n_q <= vis0;
                r_q       <= vis0 ? Red   : 8'h00;
                g_q       <= vis0 ? Green : 8'h00;
                b_q       <= vis0 ? Blue  : 8'h00;
            end
        end
    end

    assign pixel_clk   = pix_en_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank_n     = blank_n_q;
    assign frame_start = frame_start_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule
